// File: rtl/audio_in_fifo_pio.sv
// Avalon-MM audio input port: strobed samples are queued in a FIFO and
// drained by the CPU through a pop-on-read DATA register.
module audio_in_fifo_pio #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              sample_strobe,
    output logic              irq
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               overflow;
    logic               enable;
    logic               irq_en;
    logic [7:0]         threshold;

    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;
    logic        flush;
    logic        ovf_clr;
    logic        ctrl_wr;
    logic        thr_hit;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign empty    = (level == '0);
    assign full     = level[FIFO_AW];
    assign pop      = read && (address == 2'd0) && !empty;
    assign push_req = sample_strobe && enable;
    assign ctrl_wr  = write && (address == 2'd2);
    assign flush    = ctrl_wr && writedata[2];
    assign ovf_clr  = write && (address == 2'd1) && writedata[16];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push = push_req && (!full || pop) && !flush;
    assign drop = push_req && full && !pop && !flush;

    assign thr_hit = (threshold != 8'd0) && (16'(level) >= 16'(threshold));

    assign unused_ok = &{1'b0, writedata[31:17], writedata[7:3]};

    always_comb begin
        rd_mux = '0;
        unique case (address)
            2'd0: begin
                if (!empty) begin
                    rd_mux[DATA_W-1:0] = mem[rd_ptr];
                    rd_mux[31]         = 1'b1;
                end
            end
            2'd1: begin
                rd_mux[FIFO_AW:0] = level;
                rd_mux[16]        = overflow;
                rd_mux[17]        = empty;
                rd_mux[18]        = full;
            end
            2'd2: begin
                rd_mux[0]    = enable;
                rd_mux[1]    = irq_en;
                rd_mux[15:8] = threshold;
            end
            default: begin
                rd_mux[DATA_W-1:0] = in_port;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= 8'd0;
        end else if (ctrl_wr) begin
            enable    <= writedata[0];
            irq_en    <= writedata[1];
            threshold <= writedata[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
            irq      <= 1'b0;
        end else begin
            if (read) begin
                readdata <= rd_mux;
            end
            irq <= irq_en && (thr_hit || overflow);
        end
    end

endmodule

// File: tb/tb_audio_in_fifo_pio.sv
// Bench for audio_in_fifo_pio: directed steps plus a random phase, checked
// against a queue-based model of the register map.
module tb_audio_in_fifo_pio;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port = '0;
    logic          sample_strobe = 1'b0;
    logic          irq;

    int tests = 0;
    int fails = 0;

    int unsigned q[$];
    bit          m_ovf;
    bit          m_en;
    bit          m_ien;
    bit [7:0]    m_thr;
    bit          m_irq;

    audio_in_fifo_pio #(.DATA_W(DW), .FIFO_AW(AW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .sample_strobe(sample_strobe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[AW:0] = (AW + 1)'(q.size());
        s[16]   = m_ovf;
        s[17]   = (q.size() == 0);
        s[18]   = (q.size() == DEPTH);
        return s;
    endfunction

    task automatic m_reset();
        q.delete();
        m_ovf = 0;
        m_en  = 0;
        m_ien = 0;
        m_thr = 0;
        m_irq = 0;
    endtask

    // One bus cycle; model updates from the pre-edge state.
    task automatic step(string tag, bit rd, bit wr, logic [1:0] a,
                        logic [31:0] wd, bit stb, logic [DW-1:0] smp);
        logic [31:0] exp_rd;
        int          sz;
        bit          pop;
        exp_rd = '0;
        sz = q.size();
        case (a)
            2'd0: if (sz > 0) exp_rd = {1'b1, 15'd0, 16'(q[0])};
            2'd1: exp_rd = m_status();
            2'd2: exp_rd = {16'd0, m_thr, 6'd0, m_ien, m_en};
            default: exp_rd = {16'd0, smp};
        endcase
        m_irq = m_ien && ((m_thr != 0 && sz >= int'(m_thr)) || m_ovf);
        pop = rd && a == 2'd0 && sz > 0;
        if (wr && a == 2'd2 && wd[2]) begin
            q.delete();
            m_ovf = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (stb && m_en) begin
                if (sz < DEPTH || pop) q.push_back(int'(smp));
                else m_ovf = 1;
            end
            if (wr && a == 2'd1 && wd[16] && !(stb && m_en && sz == DEPTH && !pop))
                m_ovf = 0;
        end
        if (wr && a == 2'd2) begin
            m_en  = wd[0];
            m_ien = wd[1];
            m_thr = wd[15:8];
        end
        address = a;
        read = rd;
        write = wr;
        writedata = wd;
        sample_strobe = stb;
        in_port = smp;
        @(posedge clk);
        #1;
        read = 0;
        write = 0;
        sample_strobe = 0;
        if (rd) check({tag, "_rd"}, readdata, exp_rd);
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic rd_reg(string tag, logic [1:0] a);
        step(tag, 1, 0, a, 0, 0, DW'($urandom));
    endtask

    task automatic wr_reg(string tag, logic [1:0] a, logic [31:0] wd);
        step(tag, 0, 1, a, wd, 0, 0);
    endtask

    task automatic push(string tag, logic [DW-1:0] smp);
        step(tag, 0, 0, 0, 0, 1, smp);
    endtask

    task automatic idle(string tag);
        step(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] last;
        logic [31:0]   wd;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        rd_reg("empty_status", 1);
        check("empty_status_const", readdata, 32'h0002_0000);
        rd_reg("empty_data", 0);
        check("empty_data_const", readdata, 32'd0);
        rd_reg("empty_status2", 1);

        wr_reg("enable", 2, 32'h1);
        push("push_a", 16'h1234);
        push("push_b", 16'hABCD);
        rd_reg("pop_a", 0);
        check("pop_a_const", readdata, 32'h8000_1234);
        rd_reg("pop_b", 0);
        check("pop_b_const", readdata, 32'h8000_ABCD);
        rd_reg("drained", 1);

        for (int i = 0; i < 17; i++) push("fill", DW'($urandom));
        rd_reg("full_ovf", 1);
        check("full_ovf_const", readdata, 32'h0005_0010);
        wr_reg("ovf_clr", 1, 32'h0001_0000);
        rd_reg("ovf_cleared", 1);

        last = DW'($urandom);
        step("pop_push_full", 1, 0, 0, 0, 1, last);
        rd_reg("full_kept", 1);
        check("full_kept_const", readdata, 32'h0004_0010);
        for (int i = 0; i < DEPTH; i++) rd_reg("drain", 0);
        check("new_last", readdata, {16'h8000, last});

        wr_reg("thr4", 2, 32'h0000_0403);
        for (int i = 0; i < 3; i++) push("thr_push", DW'($urandom));
        idle("thr_wait");
        check("below_thr", {31'd0, irq}, 32'd0);
        push("thr_push4", DW'($urandom));
        idle("thr_lag");
        check("at_thr", {31'd0, irq}, 32'd1);
        rd_reg("thr_pop", 0);
        idle("thr_drop");
        check("after_pop", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 5; i++) push("to8", DW'($urandom));
        rd_reg("eight", 1);
        step("flush", 0, 1, 2, 32'h0000_0407, 1, DW'($urandom));
        rd_reg("flushed", 1);
        check("flushed_const", readdata, 32'h0002_0000);
        idle("flush_irq");
        check("flush_irq_low", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            wd = $urandom;
            if ($urandom_range(7) != 0) wd[2] = 0;
            if ($urandom_range(3) != 0) wd[0] = 1;
            wd[15:8] = 8'($urandom_range(20));
            step("rand", 1'($urandom), $urandom_range(3) == 0,
                 2'($urandom), wd, 1'($urandom), DW'($urandom));
        end

        step("live", 1, 0, 3, 0, 0, 16'hBEEF);
        check("live_const", readdata, 32'h0000_BEEF);
        #2;
        reset_n = 0;
        m_reset();
        #1;
        check("async_rd", readdata, 32'd0);
        check("async_irq", {31'd0, irq}, 32'd0);
        #2;
        reset_n = 1;
        @(posedge clk);
        #1;
        rd_reg("post_rst", 1);
        check("post_rst_const", readdata, 32'h0002_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
